// File: rtl/pool_pkg.sv
// Shared definitions for the pool feeder and the average-pool engine it drives.
package pool_pkg;

    localparam int unsigned POINTS_PER_CHANNEL = 49;
    localparam int unsigned DEFAULT_TIMEOUT    = 255;
    localparam int unsigned COUNT_WIDTH        = 11;
    localparam int unsigned INDEX_WIDTH        = 10;
    localparam int unsigned POINT_WIDTH        = 6;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WAIT_POOL,
        WRITE,
        FINISH
    } state_t;

    // Limit a requested channel count to what the feeder supports.
    function automatic logic [COUNT_WIDTH-1:0] clamp_channels(
        input logic [COUNT_WIDTH-1:0] requested,
        input int unsigned            max_channels
    );
        if (requested > COUNT_WIDTH'(max_channels)) begin
            return COUNT_WIDTH'(max_channels);
        end
        return requested;
    endfunction

endpackage

// File: rtl/pool_feeder.sv
// Streams 49 feature-map points per channel into an average-pool engine and
// returns one captured average per channel.
module pool_feeder
    import pool_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned MAX_CHANNELS = 1024,
    parameter int unsigned TIMEOUT      = DEFAULT_TIMEOUT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_channels,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [DATA_WIDTH-1:0]  mem_rd_data,
    output logic [DATA_WIDTH-1:0]  point_data,
    output logic                   point_valid,
    input  logic                   pool_done,
    input  logic [DATA_WIDTH-1:0]  pool_average,
    output logic                   result_valid,
    output logic [DATA_WIDTH-1:0]  result_data,
    output logic [INDEX_WIDTH-1:0] result_index,
    output logic                   busy,
    output logic                   finished,
    output logic                   error
);

    localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]        TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [POINT_WIDTH-1:0] LAST_POINT = POINT_WIDTH'(POINTS_PER_CHANNEL - 1);
    localparam logic [ADDR_WIDTH-1:0]  BASE_STEP  = ADDR_WIDTH'(POINTS_PER_CHANNEL);

    state_t                  state;
    logic [COUNT_WIDTH-1:0]  chan_total;
    logic [COUNT_WIDTH-1:0]  channel;
    logic [POINT_WIDTH-1:0]  point;
    logic [ADDR_WIDTH-1:0]   base;
    logic [TO_W-1:0]         to_cnt;

    // Read data returns one cycle after the strobe; forward it only while valid.
    assign point_data = point_valid ? mem_rd_data : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            chan_total   <= '0;
            channel      <= '0;
            point        <= '0;
            base         <= '0;
            to_cnt       <= '0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            point_valid  <= 1'b0;
            result_valid <= 1'b0;
            result_data  <= '0;
            result_index <= '0;
            busy         <= 1'b0;
            finished     <= 1'b0;
            error        <= 1'b0;
        end else begin
            mem_rd_en    <= 1'b0;
            result_valid <= 1'b0;
            finished     <= 1'b0;
            point_valid  <= mem_rd_en;

            // A completion pulse we are not waiting for is a protocol error.
            if (pool_done && (state != WAIT_POOL)) begin
                error <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        chan_total <= clamp_channels(num_channels, MAX_CHANNELS);
                        channel    <= '0;
                        point      <= '0;
                        base       <= '0;
                        if (num_channels == '0) begin
                            state <= FINISH;
                        end else begin
                            error <= 1'b0;
                            state <= READ;
                        end
                    end
                end

                READ: begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= base + ADDR_WIDTH'(point);
                    point     <= point + POINT_WIDTH'(1);
                    if (point == LAST_POINT) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    to_cnt <= '0;
                    state  <= WAIT_POOL;
                end

                WAIT_POOL: begin
                    if (pool_done) begin
                        result_data <= pool_average;
                        state       <= WRITE;
                    end else if (to_cnt == TO_LAST) begin
                        error <= 1'b1;
                        state <= FINISH;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                WRITE: begin
                    result_valid <= 1'b1;
                    result_index <= INDEX_WIDTH'(channel);
                    // Channel base advances by a constant stride; no multiply needed.
                    base         <= base + BASE_STEP;
                    channel      <= channel + COUNT_WIDTH'(1);
                    point        <= '0;
                    if ((channel + COUNT_WIDTH'(1)) == chan_total) begin
                        state <= FINISH;
                    end else begin
                        state <= READ;
                    end
                end

                FINISH: begin
                    finished <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_feeder.sv
// Bench for pool_feeder with a behavioural feature memory and average-pool engine.
module tb_pool_feeder;
    import pool_pkg::*;

    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = 16;
    localparam int unsigned TO      = 255;
    localparam int unsigned ENG_LAT = 3;

    typedef struct packed {
        logic [DW-1:0]          data;
        logic [INDEX_WIDTH-1:0] index;
    } exp_t;

    logic                   clock        = 1'b0;
    logic                   reset        = 1'b1;
    logic                   start        = 1'b0;
    logic [COUNT_WIDTH-1:0] num_channels = '0;
    logic                   mem_rd_en;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_rd_data  = '0;
    logic [DW-1:0]          point_data;
    logic                   point_valid;
    logic                   pool_done;
    logic [DW-1:0]          pool_average;
    logic                   result_valid;
    logic [DW-1:0]          result_data;
    logic [INDEX_WIDTH-1:0] result_index;
    logic                   busy;
    logic                   finished;
    logic                   error;

    pool_feeder #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .MAX_CHANNELS(1024),
        .TIMEOUT     (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .num_channels(num_channels),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .point_data  (point_data),
        .point_valid (point_valid),
        .pool_done   (pool_done),
        .pool_average(pool_average),
        .result_valid(result_valid),
        .result_data (result_data),
        .result_index(result_index),
        .busy        (busy),
        .finished    (finished),
        .error       (error)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Feature memory: one-cycle read latency
    logic [DW-1:0] mem [0:65535];
    always @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // Average-pool engine sharing the feeder reset
    logic        pool_en    = 1'b1;
    logic        stray_done = 1'b0;
    logic [63:0] acc;
    int unsigned npts;
    int unsigned dly;
    logic        pend;
    logic        eng_done;
    logic [DW-1:0] avg_q;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0; npts <= 0; dly <= 0; pend <= 1'b0; eng_done <= 1'b0; avg_q <= '0;
        end else begin
            eng_done <= 1'b0;
            if (point_valid) begin
                if (npts == POINTS_PER_CHANNEL - 1) begin
                    avg_q <= DW'((acc + 64'(point_data)) / 64'd49);
                    acc   <= '0;
                    npts  <= 0;
                    pend  <= 1'b1;
                    dly   <= ENG_LAT - 1;
                end else begin
                    acc  <= acc + 64'(point_data);
                    npts <= npts + 1;
                end
            end
            if (pend) begin
                if (dly == 0) begin
                    pend <= 1'b0;
                    if (pool_en) eng_done <= 1'b1;
                end else begin
                    dly <= dly - 1;
                end
            end
        end
    end

    assign pool_done    = eng_done | stray_done;
    assign pool_average = eng_done ? avg_q : '0;

    exp_t        exp_q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned rd_cnt = 0, res_cnt = 0, fin_cnt = 0, pv_total = 0;
    int unsigned exp_addr = 0, last_addr = 0, rd_in = 0, pv_run = 0;
    int unsigned first_rd_cyc = 0, lastpt_cyc = 0, done_cyc = 0, fin_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [COUNT_WIDTH-1:0] n);
        start = 1'b1;
        num_channels = n;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_fin(input int unsigned f0, input int unsigned budget, input string name);
        int unsigned k = 0;
        while (fin_cnt == f0 && k < budget) begin
            tick(1);
            k++;
        end
        chk({name, " finished count"}, 64'(fin_cnt - f0), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " mem_rd_en"},    64'(mem_rd_en),    64'd0);
        chk({tag, " mem_addr"},     64'(mem_addr),     64'd0);
        chk({tag, " point_valid"},  64'(point_valid),  64'd0);
        chk({tag, " point_data"},   64'(point_data),   64'd0);
        chk({tag, " result_valid"}, 64'(result_valid), 64'd0);
        chk({tag, " result_data"},  64'(result_data),  64'd0);
        chk({tag, " result_index"}, 64'(result_index), 64'd0);
        chk({tag, " busy"},         64'(busy),         64'd0);
        chk({tag, " finished"},     64'(finished),     64'd0);
        chk({tag, " error"},        64'(error),        64'd0);
    endtask

    // Monitor: address order, point runs, scoreboard pops, latency
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_addr = 0; rd_in = 0; pv_run = 0; pv_total = 0;
            end else begin
                if (start && !busy) begin
                    exp_addr = 0;
                    pv_total = 0;
                end
                if (mem_rd_en) begin
                    chk("mem_addr order", 64'(mem_addr), 64'(exp_addr));
                    exp_addr++;
                    last_addr = 32'(mem_addr);
                    rd_cnt++;
                    if (rd_in == 0) first_rd_cyc = cyc;
                    rd_in = (rd_in == POINTS_PER_CHANNEL - 1) ? 0 : rd_in + 1;
                end
                if (point_valid) begin
                    pv_run++;
                    pv_total++;
                    if (pv_run == POINTS_PER_CHANNEL) lastpt_cyc = cyc;
                end else if (pv_run != 0) begin
                    chk("point_valid run length", 64'(pv_run), 64'd49);
                    pv_run = 0;
                end
                if (eng_done) done_cyc = cyc;
                if (result_valid) begin
                    res_cnt++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected result: got data=%0d index=%0d, expected none",
                                 result_data, result_index);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result_data",  64'(result_data),  64'(e.data));
                        chk("result_index", 64'(result_index), 64'(e.index));
                        chk("channel latency", 64'(cyc - first_rd_cyc),
                            64'(51 + done_cyc - lastpt_cyc));
                    end
                end
                if (finished) begin
                    fin_cnt++;
                    fin_cyc = cyc;
                end
            end
        end
    endtask

    initial begin
        int unsigned f0, r0, d0, k;
        fork
            monitor();
        join_none

        // Reset state
        reset = 1'b1;
        tick(3);
        check_all_zero("reset");
        reset = 1'b0;
        tick(2);

        for (int i = 0; i < 65536; i++) mem[i] = DW'(i);

        // Two channels over an address ramp
        exp_q.push_back('{data: 32'd24, index: 10'd0});
        exp_q.push_back('{data: 32'd73, index: 10'd1});
        f0 = fin_cnt; r0 = res_cnt; d0 = rd_cnt;
        do_start(11'd2);
        wait_fin(f0, 1000, "two channels");
        chk("two channels results", 64'(res_cnt - r0), 64'd2);
        chk("two channels reads",   64'(rd_cnt - d0),  64'd98);
        chk("two channels last addr", 64'(last_addr), 64'd97);
        chk("two channels error",   64'(error), 64'd0);
        chk("two channels busy",    64'(busy),  64'd0);
        chk("two channels queue",   64'(exp_q.size()), 64'd0);

        // Zero channels: straight to FINISH
        f0 = fin_cnt; r0 = res_cnt; d0 = rd_cnt;
        do_start(11'd0);
        chk("zero finished early", 64'(finished), 64'd0);
        chk("zero busy",           64'(busy),     64'd1);
        tick(1);
        chk("zero finished",       64'(finished), 64'd1);
        chk("zero busy cleared",   64'(busy),     64'd0);
        tick(2);
        chk("zero results", 64'(res_cnt - r0), 64'd0);
        chk("zero reads",   64'(rd_cnt - d0),  64'd0);
        chk("zero finish count", 64'(fin_cnt - f0), 64'd1);

        // Pool engine silent: timeout
        pool_en = 1'b0;
        f0 = fin_cnt; r0 = res_cnt; d0 = rd_cnt;
        do_start(11'd1);
        wait_fin(f0, 600, "timeout");
        chk("timeout error",   64'(error), 64'd1);
        chk("timeout results", 64'(res_cnt - r0), 64'd0);
        chk("timeout reads",   64'(rd_cnt - d0),  64'd49);
        chk("timeout delay after last point", 64'(fin_cyc - lastpt_cyc), 64'(TO + 1));
        pool_en = 1'b1;
        tick(2);

        // Second start and stray pool_done during READ
        exp_q.push_back('{data: 32'd24, index: 10'd0});
        f0 = fin_cnt; r0 = res_cnt; d0 = rd_cnt;
        do_start(11'd1);
        chk("new job clears error", 64'(error), 64'd0);
        tick(5);
        do_start(11'd3);
        tick(10);
        stray_done = 1'b1;
        tick(1);
        stray_done = 1'b0;
        chk("stray pool_done error", 64'(error), 64'd1);
        wait_fin(f0, 500, "stray");
        chk("stray results", 64'(res_cnt - r0), 64'd1);
        chk("stray reads",   64'(rd_cnt - d0),  64'd49);
        chk("stray error sticky", 64'(error), 64'd1);
        chk("stray queue", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of channel 3, then a fresh one-channel job
        exp_q.push_back('{data: 32'd24,  index: 10'd0});
        exp_q.push_back('{data: 32'd73,  index: 10'd1});
        exp_q.push_back('{data: 32'd122, index: 10'd2});
        do_start(11'd5);
        k = 0;
        while (pv_total < 3 * POINTS_PER_CHANNEL + 20 && k < 2000) begin
            tick(1);
            k++;
        end
        chk("reached channel 3 point 20", 64'(pv_total >= 3 * POINTS_PER_CHANNEL + 20), 64'd1);
        chk("results before reset", 64'(exp_q.size()), 64'd0);
        reset = 1'b1;
        #1;
        check_all_zero("mid-job reset");
        tick(1);
        reset = 1'b0;
        tick(2);
        exp_q.push_back('{data: 32'd24, index: 10'd0});
        f0 = fin_cnt;
        do_start(11'd1);
        wait_fin(f0, 500, "after reset");
        chk("after reset error", 64'(error), 64'd0);
        chk("after reset queue", 64'(exp_q.size()), 64'd0);

        // Full-size job with constant words; oversize request clamps to 1024
        for (int i = 0; i < 65536; i++) mem[i] = 32'hFFFF_FFFF;
        for (int i = 0; i < 65536; i++) mem[i] = 32'd87652393;
        for (int i = 0; i < 1024; i++) exp_q.push_back('{data: 32'd87652393, index: 10'(i)});
        f0 = fin_cnt; r0 = res_cnt; d0 = rd_cnt;
        do_start(11'd2047);
        wait_fin(f0, 70000, "full");
        chk("full results",   64'(res_cnt - r0), 64'd1024);
        chk("full reads",     64'(rd_cnt - d0),  64'd50176);
        chk("full last addr", 64'(last_addr),    64'd50175);
        chk("full error",     64'(error),        64'd0);
        chk("full queue",     64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pool_feeder.md
POOL_FEEDER -- requirements
Module: pool_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of feature-map words, points and averages.
REQ-002 Parameter ADDR_WIDTH, default 16, feature-memory word-address width; SHALL satisfy 2^ADDR_WIDTH >= 49*MAX_CHANNELS.
REQ-003 Parameter MAX_CHANNELS, default 1024, largest accepted channel count.
REQ-004 Parameter TIMEOUT, default 255, cycles allowed between the last point and pool_done.
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; begins a job when idle.
REQ-008 num_channels  in  11  channels in the job, 0..MAX_CHANNELS, sampled on an accepted start.
REQ-009 mem_rd_en  out  1  feature-memory read strobe.
REQ-010 mem_addr  out  ADDR_WIDTH  read word address.
REQ-011 mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 point_data  out  DATA_WIDTH  point sent to the average-pool engine.
REQ-013 point_valid  out  1  point_data valid this cycle.
REQ-014 pool_done  in  1  one-cycle completion pulse from the pool engine.
REQ-015 pool_average  in  DATA_WIDTH  average, valid while pool_done=1.
REQ-016 result_valid  out  1  one-cycle pulse, result_data/result_index valid.
REQ-017 result_data  out  DATA_WIDTH  captured average.
REQ-018 result_index  out  10  channel number of result_data.
REQ-019 busy  out  1  high from the cycle after an accepted start until finished.
REQ-020 finished  out  1  one-cycle pulse at job end.
REQ-021 error  out  1  sticky; set on timeout or pool_done seen outside WAIT_POOL.

Function
REQ-022 States SHALL be IDLE, READ, DRAIN, WAIT_POOL, WRITE, FINISH.
REQ-023 IDLE: start=1 latches num_channels; if 0 go to FINISH, else go to READ with channel=0, point=0, base=0 and clear error.
REQ-024 READ: mem_rd_en=1, mem_addr=base+point, point increments each cycle; after point 48 go to DRAIN.
REQ-025 point_valid SHALL be the 1-cycle delayed mem_rd_en, and point_data SHALL equal mem_rd_data; each channel yields exactly 49 consecutive point_valid cycles.
REQ-026 DRAIN: one cycle for the last read to return, then WAIT_POOL with the timeout counter cleared.
REQ-027 WAIT_POOL: on pool_done capture pool_average into result_data and go to WRITE; else increment the counter; on reaching TIMEOUT set error and go to FINISH.
REQ-028 WRITE: result_valid=1 for one cycle with result_index=channel; then base+=49 and channel+=1, go to READ if channels remain, else FINISH.
REQ-029 FINISH: finished=1 for one cycle, busy=0, return to IDLE.
REQ-030 The base address SHALL be accumulated by adding 49; no multiplier is permitted.
REQ-031 start while not IDLE SHALL be ignored; pool_done outside WAIT_POOL SHALL set error and is otherwise ignored.
REQ-032 num_channels > MAX_CHANNELS SHALL be clamped to MAX_CHANNELS.
REQ-033 Per-channel latency from the first mem_rd_en to result_valid SHALL be 51 cycles plus the pool-engine latency.

Reset
REQ-034 reset SHALL force state IDLE and drive every output to 0, including result_data, result_index and error, regardless of any in-flight read or pool job.
REQ-035 The pool engine SHALL share this reset, so that a reset mid-channel discards partial sums at both ends.

Structure
REQ-036 The state enum, the POINTS_PER_CHANNEL=49 constant and the default TIMEOUT SHALL live in shared package pool_pkg, used by the pool engine too.
REQ-037 The block SHALL be flat, with no sub-modules; the bench instantiates it together with the pool engine and a behavioural memory.

Verification
REQ-038 Memory word[i]=i, num_channels=2 -> averages 24 and 73, result_index 0 then 1, then finished; mem_addr covers 0..97 exactly once.
REQ-039 num_channels=0 -> finished 2 cycles after start, no mem_rd_en and no result_valid.
REQ-040 pool_done held low, TIMEOUT=255 -> error=1 and finished 255 cycles after DRAIN; no result_valid.
REQ-041 Second start during a job, and pool_done pulsed during READ -> job unaffected, error=1 after the stray pool_done.
REQ-042 reset asserted at point 20 of channel 3 -> all outputs 0 immediately; a restarted job with num_channels=1 returns the correct average.
REQ-043 All words = 0xFFFF_FFFF/49 with num_channels=1024 -> 1024 equal results, final mem_addr = 50175, no address wrap.
